// File: rtl/cda_counter_pkg.sv
// rtl/cda_counter_pkg.sv - shared constants and helpers for the CDA limit counter
package cda_counter_pkg;

    localparam int WIDTH_DEF  = 20;
    localparam int STEP_W_DEF = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    // Conflicting or absent requests both mean hold
    function automatic dir_e decode_dir(input logic up, input logic down);
        if (up && !down) begin
            return DIR_UP;
        end else if (down && !up) begin
            return DIR_DOWN;
        end else begin
            return DIR_HOLD;
        end
    endfunction

endpackage

// File: rtl/udc_next_calc.sv
// rtl/udc_next_calc.sv - combinational next-count, clamp and limit-crossing generator
module udc_next_calc
    import cda_counter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              mode_sat,
    input  logic [WIDTH-1:0]  lim_lo,
    input  logic [WIDTH-1:0]  lim_hi,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  clamp_val,
    output logic [WIDTH-1:0]  step_count,
    output logic              step_ovf,
    output logic              step_unf
);

    // One extra bit keeps count+step and lim_lo+step free of modular wrap
    logic [WIDTH:0]   ext_cnt;
    logic [WIDTH:0]   ext_step;
    logic [WIDTH:0]   ext_hi;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   lo_plus;
    logic [WIDTH-1:0] step_w;
    dir_e             dir;

    assign ext_cnt  = {1'b0, count};
    assign ext_step = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign ext_hi   = {1'b0, lim_hi};
    assign up_sum   = ext_cnt + ext_step;
    assign lo_plus  = {1'b0, lim_lo} + ext_step;
    assign step_w   = {{(WIDTH - STEP_W){1'b0}}, step};
    assign dir      = decode_dir(up, down);

    // Load value clamped into the current window
    always_comb begin
        clamp_val = load_val;
        if (load_val < lim_lo) begin
            clamp_val = lim_lo;
        end else if (load_val > lim_hi) begin
            clamp_val = lim_hi;
        end
    end

    // Enabled-cycle result: out-of-range recovery first, otherwise one step
    always_comb begin
        step_count = count;
        step_ovf   = 1'b0;
        step_unf   = 1'b0;
        if (count < lim_lo) begin
            step_count = lim_lo;
        end else if (count > lim_hi) begin
            step_count = lim_hi;
        end else begin
            case (dir)
                DIR_UP: begin
                    if (up_sum > ext_hi) begin
                        step_ovf   = 1'b1;
                        step_count = (mode_sat == MODE_SAT) ? lim_hi : lim_lo;
                    end else begin
                        step_count = up_sum[WIDTH-1:0];
                    end
                end
                DIR_DOWN: begin
                    if (ext_cnt < lo_plus) begin
                        step_unf   = 1'b1;
                        step_count = (mode_sat == MODE_SAT) ? lim_lo : lim_hi;
                    end else begin
                        step_count = count - step_w;
                    end
                end
                default: begin
                    step_count = count;
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_limit_counter.sv
// rtl/updown_limit_counter.sv - up/down counter with step, runtime limits, wrap/saturate and flags
module updown_limit_counter
    import cda_counter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              mode_sat,
    input  logic [WIDTH-1:0]  lim_lo,
    input  logic [WIDTH-1:0]  lim_hi,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_lo,
    output logic              at_hi,
    output logic              ovf,
    output logic              unf,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    output logic              cfg_err
);

    logic [WIDTH-1:0] clamp_val;
    logic [WIDTH-1:0] step_count;
    logic             step_ovf;
    logic             step_unf;
    logic             cfg_bad;
    logic [WIDTH-1:0] next_count;
    logic             next_ovf;
    logic             next_unf;

    assign cfg_bad = (lim_lo > lim_hi);

    udc_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count),
        .up         (up),
        .down       (down),
        .step       (step),
        .mode_sat   (mode_sat),
        .lim_lo     (lim_lo),
        .lim_hi     (lim_hi),
        .load_val   (load_val),
        .clamp_val  (clamp_val),
        .step_count (step_count),
        .step_ovf   (step_ovf),
        .step_unf   (step_unf)
    );

    // Priority: inverted limits freeze the counter, then load, then enabled counting
    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        if (!cfg_bad) begin
            if (load) begin
                next_count = clamp_val;
            end else if (en) begin
                next_count = step_count;
                next_ovf   = step_ovf;
                next_unf   = step_unf;
            end
        end
    end

    // Register count and every flag; a new pulse beats a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            at_lo      <= 1'b0;
            at_hi      <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            count      <= next_count;
            at_lo      <= (next_count == lim_lo);
            at_hi      <= (next_count == lim_hi);
            ovf        <= next_ovf;
            unf        <= next_unf;
            ovf_sticky <= next_ovf | (ovf_sticky & ~clr_flags);
            unf_sticky <= next_unf | (unf_sticky & ~clr_flags);
            cfg_err    <= cfg_bad;
        end
    end

endmodule

// File: tb/tb_updown_limit_counter.sv
// tb/tb_updown_limit_counter.sv - self-checking bench for updown_limit_counter
module tb_updown_limit_counter;

    localparam int W  = 20;
    localparam int SW = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          up;
    logic          down;
    logic [SW-1:0] step;
    logic          mode_sat;
    logic [W-1:0]  lim_lo;
    logic [W-1:0]  lim_hi;
    logic          load;
    logic [W-1:0]  load_val;
    logic          clr_flags;
    logic [W-1:0]  count;
    logic          at_lo;
    logic          at_hi;
    logic          ovf;
    logic          unf;
    logic          ovf_sticky;
    logic          unf_sticky;
    logic          cfg_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    int m_count = 0;
    bit m_ovf = 0, m_unf = 0, m_os = 0, m_us = 0, m_alo = 0, m_ahi = 0, m_cfg = 0;

    updown_limit_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
        .down       (down),
        .step       (step),
        .mode_sat   (mode_sat),
        .lim_lo     (lim_lo),
        .lim_hi     (lim_hi),
        .load       (load),
        .load_val   (load_val),
        .clr_flags  (clr_flags),
        .count      (count),
        .at_lo      (at_lo),
        .at_hi      (at_hi),
        .ovf        (ovf),
        .unf        (unf),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model one clock edge from the behavioural rules using plain integers
    task automatic model_edge();
        int lo, hi, s;
        lo = int'(lim_lo);
        hi = int'(lim_hi);
        s  = int'(step);
        m_ovf = 0;
        m_unf = 0;
        if (reset) begin
            m_count = 0; m_os = 0; m_us = 0; m_alo = 0; m_ahi = 0; m_cfg = 0;
            return;
        end
        m_cfg = (lo > hi);
        if (!m_cfg) begin
            if (load) begin
                m_count = (int'(load_val) < lo) ? lo : ((int'(load_val) > hi) ? hi : int'(load_val));
            end else if (en) begin
                if (m_count < lo) m_count = lo;
                else if (m_count > hi) m_count = hi;
                else if (up && !down) begin
                    if (m_count + s > hi) begin
                        m_ovf = 1;
                        m_count = mode_sat ? hi : lo;
                    end else m_count = m_count + s;
                end else if (down && !up) begin
                    if (m_count - s < lo) begin
                        m_unf = 1;
                        m_count = mode_sat ? lo : hi;
                    end else m_count = m_count - s;
                end
            end
        end
        m_os = m_ovf ? 1'b1 : (clr_flags ? 1'b0 : m_os);
        m_us = m_unf ? 1'b1 : (clr_flags ? 1'b0 : m_us);
        m_alo = (m_count == lo);
        m_ahi = (m_count == hi);
    endtask

    // Advance one clock and compare every output to the model
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".count"}, count, W'(m_count));
        chk({tag, ".at_lo"}, W'(at_lo), W'(m_alo));
        chk({tag, ".at_hi"}, W'(at_hi), W'(m_ahi));
        chk({tag, ".ovf"}, W'(ovf), W'(m_ovf));
        chk({tag, ".unf"}, W'(unf), W'(m_unf));
        chk({tag, ".ovf_sticky"}, W'(ovf_sticky), W'(m_os));
        chk({tag, ".unf_sticky"}, W'(unf_sticky), W'(m_us));
        chk({tag, ".cfg_err"}, W'(cfg_err), W'(m_cfg));
    endtask

    task automatic idle();
        reset = 0; en = 0; up = 0; down = 0; step = '0;
        load = 0; clr_flags = 0;
    endtask

    task automatic do_load(input int v, input string tag);
        idle();
        load = 1; load_val = W'(v);
        tick(tag);
        load = 0;
    endtask

    initial begin
        idle();
        mode_sat = 1; lim_lo = '0; lim_hi = 20'd100; load_val = '0;
        reset = 1;
        tick("rst0");

        // Reset mid-count at 37
        do_load(37, "ld37");
        chk("count37", count, 20'd37);
        en = 1; up = 1; step = 4'd1; reset = 1;
        tick("rst37");
        chk("rst37_zero", count, 20'd0);

        // Saturate at upper limit
        idle(); lim_lo = 20'd10; lim_hi = 20'd20; mode_sat = 1;
        do_load(18, "ld18");
        en = 1; up = 1; step = 4'd3;
        tick("sat1");
        chk("sat1_cnt", count, 20'd20);
        chk("sat1_ovf", W'(ovf), 20'd1);
        tick("sat2");
        idle();
        tick("sat_idle");
        chk("sat_pulse_gone", W'(ovf), 20'd0);

        // Wrap down then clear stickies
        mode_sat = 0;
        do_load(11, "ld11");
        en = 1; down = 1; step = 4'd2;
        tick("wrapdn");
        chk("wrapdn_cnt", count, 20'd20);
        idle(); clr_flags = 1;
        tick("clr");
        chk("clr_unf_s", W'(unf_sticky), 20'd0);

        // Load clamp, en low
        lim_lo = 20'd5; lim_hi = 20'd100;
        do_load(200, "ldhi");
        chk("ldhi_cnt", count, 20'd100);
        do_load(0, "ldlo");
        chk("ldlo_cnt", count, 20'd5);

        // Conflicting direction holds
        do_load(50, "ld50");
        en = 1; up = 1; down = 1; step = 4'd7;
        tick("updn");

        // Clear coincident with ovf: set wins
        lim_lo = 20'd10; lim_hi = 20'd20; mode_sat = 1;
        do_load(20, "ld20");
        en = 1; up = 1; step = 4'd1; clr_flags = 1;
        tick("clr_vs_ovf");
        chk("clr_vs_ovf_s", W'(ovf_sticky), 20'd1);

        // Inverted limits freeze count
        idle(); lim_lo = 20'd30; lim_hi = 20'd20;
        tick("cfg1");
        load = 1; load_val = 20'd25;
        tick("cfg_ld");
        load = 0; en = 1; up = 1; step = 4'd5;
        tick("cfg_up");
        chk("cfg_hold", count, 20'd20);

        // Full-range boundary, no modular wrap
        idle(); lim_lo = '0; lim_hi = 20'hFFFFF; mode_sat = 1;
        do_load(MAXV - 1, "ldmax");
        en = 1; up = 1; step = 4'd15;
        tick("bnd");
        chk("bnd_cnt", count, 20'hFFFFF);
        mode_sat = 0;
        tick("bnd_wrap");

        // Degenerate range
        idle(); lim_lo = 20'd7; lim_hi = 20'd7;
        en = 1; up = 1; step = 4'd1;
        tick("deg_rec");
        tick("deg_up");
        up = 0; down = 1;
        tick("deg_dn");
        step = '0;
        tick("deg_zero");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            en        = ($urandom_range(0, 3) != 0);
            up        = $urandom_range(0, 1);
            down      = $urandom_range(0, 1);
            step      = SW'($urandom_range(0, 15));
            mode_sat  = $urandom_range(0, 1);
            load      = ($urandom_range(0, 7) == 0);
            load_val  = W'($urandom_range(0, 63));
            clr_flags = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                lim_lo = W'($urandom_range(0, 40));
                lim_hi = W'($urandom_range(0, 50));
            end else if ($urandom_range(0, 199) == 0) begin
                lim_lo = W'($urandom_range(0, 3));
                lim_hi = W'(MAXV - $urandom_range(0, 3));
                load_val = W'(MAXV - $urandom_range(0, 20));
            end
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_limit_counter.md
Name: updown_limit_counter

Overview:
Parametrised successor of the team's basic up/down counter, used in the CDA Block for event tallying and threshold tracking. Adds:
- programmable step size
- runtime lower and upper limits
- wrap or saturate mode
- synchronous load
- count enable
- terminal-count flags, plus pulse and sticky overflow/underflow flags

All outputs are registered, one clock domain.

Parameters:
WIDTH, 20, counter and limit width in bits (unsigned).
STEP_W, 4, width of the step input; step range 0..2^STEP_W-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  count enable; up/down ignored when 0 (load still honoured).
up  in  1  count-up request.
down  in  1  count-down request.
step  in  STEP_W  increment/decrement amount.
mode_sat  in  1  1 = saturate at limits, 0 = wrap to opposite limit.
lim_lo  in  WIDTH  lower limit (inclusive).
lim_hi  in  WIDTH  upper limit (inclusive).
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value for load.
clr_flags  in  1  clears sticky flags.
count  out  WIDTH  current count.
at_lo  out  1  count == lim_lo.
at_hi  out  1  count == lim_hi.
ovf  out  1  one-cycle pulse: up step crossed lim_hi.
unf  out  1  one-cycle pulse: down step crossed lim_lo.
ovf_sticky  out  1  latched ovf.
unf_sticky  out  1  latched unf.
cfg_err  out  1  registered lim_lo > lim_hi.

Behaviour:
- Reset (reset=1 at edge): all outputs cleared, including count, every flag and cfg_err. Priority over everything.
- Latency: every input takes effect on count and all flags at the next rising edge. at_lo/at_hi are computed from the next count and the current limits, so they align with count.
- Priority after reset:
  - cfg_err case first: count holds; load and counting are ignored.
  - load next: count <= clamp(load_val, lim_lo, lim_hi). No ovf/unf.
  - then en-gated counting.
- Out-of-range recovery: en=1 with count outside [lim_lo, lim_hi] (limits changed at runtime) forces count to the nearest limit that cycle. up/down are ignored; no ovf/unf.
- Direction: up&!down = increment; down&!up = decrement; both or neither = hold. step=0 = hold, no flags.
- Arithmetic: sums use WIDTH+1 bits, so there is no silent modular wrap.
  - Up: if count+step > lim_hi, then ovf=1; count <= lim_hi (sat) or lim_lo (wrap).
  - Down: if count < lim_lo+step (WIDTH+1-bit compare), then unf=1; count <= lim_lo (sat) or lim_hi (wrap).
  - Reaching exactly a limit is not ovf/unf.
- Degenerate range lim_lo == lim_hi: count is pinned at that value; any nonzero up step gives ovf, any nonzero down step gives unf.
- Sticky flags: set on the corresponding pulse, cleared by clr_flags. If clr_flags and a new pulse occur in the same cycle, the set wins.
- mode_sat and limits are sampled every cycle. A mid-run change affects only the next step.
- Reset asserted mid-count discards the operation in progress; the count restarts from 0 and the first enabled cycle after reset applies out-of-range recovery if lim_lo > 0.

Decomposition:
- Shared package cda_counter_pkg holds:
  - MODE_WRAP = 1'b0 and MODE_SAT = 1'b1
  - default WIDTH/STEP_W constants
- One natural sub-module, udc_next_calc: a purely combinational next-count and flag generator (clamp, bound compare, wrap/saturate select).
- The top level holds the registers, priority and sticky logic.

Test Plan:
- Reset: drive reset=1 mid-count at count=37 -> next edge count=0, all flags 0, cfg_err 0.
- Saturate: lo=10, hi=20, mode_sat=1, count=18, step=3, up -> count=20, ovf pulse 1 cycle, ovf_sticky=1, at_hi=1; a further up leaves count 20 with ovf again.
- Wrap down: lo=10, hi=20, mode_sat=0, count=11, step=2, down -> count=20, unf=1, at_hi=1. Then clr_flags -> unf_sticky=0.
- Load clamp: lo=5, hi=100, load_val=200 -> count=100, no ovf. load_val=0 -> count=5. Load with en=0 still loads.
- Conflicts: up=down=1 at count=50 -> hold. clr_flags coincident with ovf -> ovf_sticky stays 1. lo=30, hi=20 -> cfg_err=1, count holds through load and up.
- Boundaries: WIDTH=20, lo=0, hi=2^20-1, count=2^20-2, step=15, up, sat -> count=2^20-1, ovf=1, with no modular wrap to small values.
